// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB register-file slave: FSM states,
// register indices, the ID word and the transfer-error decode.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    localparam logic [2:0]  REG_ID   = 3'd0;
    localparam logic [2:0]  REG_WCNT = 3'd7;
    localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;

    // Out-of-window, misaligned, or a write aimed at one of the read-only words.
    function automatic logic xfer_err(input logic [31:0] addr,
                                      input logic        wr,
                                      input logic [26:0] base_hi);
        logic ro_target;
        ro_target = (addr[4:2] == REG_ID) || (addr[4:2] == REG_WCNT);
        return (addr[31:5] != base_hi) || (addr[1:0] != 2'b00) || (wr && ro_target);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a bridge (master) and the register-file slave.
interface apb_slave_regfile_if;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Psel, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Psel, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regfile_regbank.sv
// Eight-word register bank: read-only ID, six R/W words and a wrapping
// count of successful writes, with a combinational read mux.
module apb_slave_regbank
    import apb_slave_pkg::*;
(
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [2:0]  rd_idx_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] rw_q [1:6];
    logic [31:0] wcnt_q;
    logic        wr_ok_s;

    assign wr_ok_s = wr_en_i && (wr_idx_i != REG_ID) && (wr_idx_i != REG_WCNT);

    // Writable words and the successful-write counter, which wraps naturally.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            for (int i = 1; i <= 6; i++) begin
                rw_q[i] <= 32'd0;
            end
            wcnt_q <= 32'd0;
        end else if (wr_ok_s) begin
            rw_q[wr_idx_i] <= wr_data_i;
            wcnt_q         <= wcnt_q + 32'd1;
        end
    end

    // Read mux over the full word index.
    always_comb begin
        rd_data_o = 32'd0;
        case (rd_idx_i)
            REG_ID:   rd_data_o = ID_VALUE;
            REG_WCNT: rd_data_o = wcnt_q;
            default:  rd_data_o = rw_q[rd_idx_i];
        endcase
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with configurable wait states: transfer FSM, wait counter and
// registered bus outputs in front of the register bank.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                Hclk,
    input  logic                Hreset,
    apb_slave_regfile_if.slave  apb,
    output logic                proto_err
);

    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] prdata_q;
    logic        proto_q;

    logic        setup_s;
    logic        access_s;
    logic [31:0] nxt_addr_s;
    logic        nxt_write_s;
    logic        err_s;
    logic        wr_en_s;
    logic [31:0] rd_data_s;
    logic [31:0] rd_val_s;

    assign setup_s  = apb.Psel & ~apb.Penable;
    assign access_s = apb.Psel &  apb.Penable;
    assign wr_en_s  = (state_q == ST_READY) & access_s & write_q & ~pslverr_q;

    // Entering READY from WAIT uses the latched transfer; from a setup phase, the live bus.
    always_comb begin
        nxt_addr_s  = apb.Paddr;
        nxt_write_s = apb.Pwrite;
        if (state_q == ST_WAIT) begin
            nxt_addr_s  = addr_q;
            nxt_write_s = write_q;
        end else begin
            nxt_addr_s  = apb.Paddr;
            nxt_write_s = apb.Pwrite;
        end
    end

    assign err_s = xfer_err(nxt_addr_s, nxt_write_s, BASE_ADDR[31:5]);

    // Read data presented in READY; zero for writes and failed reads.
    always_comb begin
        rd_val_s = 32'd0;
        if (nxt_write_s || err_s) begin
            rd_val_s = 32'd0;
        end else begin
            rd_val_s = rd_data_s;
        end
    end

    apb_slave_regbank u_bank (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (addr_q[4:2]),
        .wr_data_i (apb.Pwdata),
        .rd_idx_i  (nxt_addr_s[4:2]),
        .rd_data_o (rd_data_s)
    );

    // Transfer FSM; bus outputs default low and are only raised on entry to READY.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= 32'd0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            proto_q   <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            if (setup_s && (state_q != ST_WAIT)) begin
                addr_q  <= apb.Paddr;
                write_q <= apb.Pwrite;
                if (WS_LOAD == 3'd0) begin
                    state_q   <= ST_READY;
                    pready_q  <= 1'b1;
                    pslverr_q <= err_s;
                    prdata_q  <= rd_val_s;
                end else begin
                    state_q <= ST_WAIT;
                    cnt_q   <= WS_LOAD;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                        if (access_s) begin
                            proto_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (!apb.Psel) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 3'd0;
                            proto_q <= 1'b1;
                        end else if (apb.Penable) begin
                            if (cnt_q <= 3'd1) begin
                                state_q   <= ST_READY;
                                cnt_q     <= 3'd0;
                                pready_q  <= 1'b1;
                                pslverr_q <= err_s;
                                prdata_q  <= rd_val_s;
                            end else begin
                                cnt_q <= cnt_q - 3'd1;
                            end
                        end
                    end
                    ST_READY: begin
                        // Reaching here with Psel high means Penable is high: completion.
                        state_q <= ST_IDLE;
                        if (!apb.Psel) begin
                            proto_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign apb.Pready  = pready_q;
    assign apb.Pslverr = pslverr_q;
    assign apb.Prdata  = prdata_q;
    assign proto_err   = proto_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three slaves (0, 1 and 3 wait states) on one shared APB bus,
// each selected by its own Pselx bit.
module tb_apb_slave_regfile;

    logic        hclk;
    logic        hreset;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    logic        rdy  [3];
    logic        serr [3];
    logic        perr [3];
    logic [31:0] rdat [3];

    int total = 0;
    int bad   = 0;
    logic        swap_en   = 1'b0;
    logic [31:0] swap_addr = 32'd0;

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus1 ();
    apb_slave_regfile_if bus2 ();

    assign bus0.Psel = pselx[0]; assign bus0.Penable = penable; assign bus0.Pwrite = pwrite;
    assign bus0.Paddr = paddr;   assign bus0.Pwdata = pwdata;
    assign bus1.Psel = pselx[1]; assign bus1.Penable = penable; assign bus1.Pwrite = pwrite;
    assign bus1.Paddr = paddr;   assign bus1.Pwdata = pwdata;
    assign bus2.Psel = pselx[2]; assign bus2.Penable = penable; assign bus2.Pwrite = pwrite;
    assign bus2.Paddr = paddr;   assign bus2.Pwdata = pwdata;

    assign rdy[0] = bus0.Pready; assign serr[0] = bus0.Pslverr; assign rdat[0] = bus0.Prdata;
    assign rdy[1] = bus1.Pready; assign serr[1] = bus1.Pslverr; assign rdat[1] = bus1.Prdata;
    assign rdy[2] = bus2.Pready; assign serr[2] = bus2.Pslverr; assign rdat[2] = bus2.Prdata;

    apb_slave_regfile #(.BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) u_ws0 (
        .Hclk(hclk), .Hreset(hreset), .apb(bus0.slave), .proto_err(perr[0]));
    apb_slave_regfile #(.BASE_ADDR(32'h8000_0000), .WAIT_STATES(1)) u_ws1 (
        .Hclk(hclk), .Hreset(hreset), .apb(bus1.slave), .proto_err(perr[1]));
    apb_slave_regfile #(.BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) u_ws3 (
        .Hclk(hclk), .Hreset(hreset), .apb(bus2.slave), .proto_err(perr[2]));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        @(posedge hclk); @(negedge hclk);
    endtask

    // One transfer starting at a falling edge; checks data, error and wait count.
    task automatic op(input string tag, input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_data,
                      input logic exp_err, input int exp_waits, input bit hold);
        int waits;
        pselx    = 3'b000;
        pselx[d] = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = wdata;
        @(posedge hclk); @(negedge hclk);
        penable = 1'b1;
        if (swap_en) paddr = swap_addr;
        waits = 0;
        while (!rdy[d] && waits < 20) begin
            @(posedge hclk); @(negedge hclk);
            waits++;
        end
        chk({tag, "_ready"}, {31'd0, rdy[d]}, 32'd1);
        chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        chk({tag, "_slverr"}, {31'd0, serr[d]}, {31'd0, exp_err});
        if (!wr) chk({tag, "_rdata"}, rdat[d], exp_data);
        @(posedge hclk); @(negedge hclk);
        chk({tag, "_ready_drop"}, {31'd0, rdy[d]}, 32'd0);
        if (!hold) idle();
    endtask

    initial begin
        hreset  = 1'b1;
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        repeat (3) @(negedge hclk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out", {rdy[i], serr[i], perr[i]} == 3'b000 ? rdat[i] : 32'hFFFF_FFFF, 32'd0);
        end
        hreset = 1'b0;
        @(negedge hclk);

        // One wait state: write, read back, write counter.
        op("ws1_wr_r1", 1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'd0, 1'b0, 1, 1'b0);
        op("ws1_rd_r1", 1, 1'b0, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
        op("ws1_rd_r7", 1, 1'b0, 32'h8000_001C, 32'd0, 32'd1, 1'b0, 1, 1'b0);

        // Error transfers leave state untouched.
        op("ws1_wr_r0", 1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'd0, 1'b1, 1, 1'b0);
        op("ws1_wr_mis", 1, 1'b1, 32'h8000_0006, 32'h0000_0002, 32'd0, 1'b1, 1, 1'b0);
        op("ws1_rd_oow", 1, 1'b0, 32'h9000_0000, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        op("ws1_rd_id", 1, 1'b0, 32'h8000_0000, 32'd0, 32'hA5B0_0001, 1'b0, 1, 1'b0);
        op("ws1_rd_r1b", 1, 1'b0, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
        op("ws1_rd_r7b", 1, 1'b0, 32'h8000_001C, 32'd0, 32'd1, 1'b0, 1, 1'b0);

        // Address changed during the access phase must not redirect the write.
        swap_en   = 1'b1;
        swap_addr = 32'h8000_000C;
        op("ws1_wr_swap", 1, 1'b1, 32'h8000_0008, 32'h1111_2222, 32'd0, 1'b0, 1, 1'b0);
        swap_en = 1'b0;
        op("ws1_rd_r2", 1, 1'b0, 32'h8000_0008, 32'd0, 32'h1111_2222, 1'b0, 1, 1'b0);
        op("ws1_rd_r3", 1, 1'b0, 32'h8000_000C, 32'd0, 32'd0, 1'b0, 1, 1'b0);
        op("ws1_rd_r7c", 1, 1'b0, 32'h8000_001C, 32'd0, 32'd2, 1'b0, 1, 1'b0);
        chk("ws1_proto", {31'd0, perr[1]}, 32'd0);

        // Write counter wrap.
        force u_ws1.u_bank.wcnt_q = 32'hFFFF_FFFF;
        #1;
        release u_ws1.u_bank.wcnt_q;
        @(negedge hclk);
        op("ws1_rd_r7max", 1, 1'b0, 32'h8000_001C, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
        op("ws1_wr_r3", 1, 1'b1, 32'h8000_000C, 32'h0F0F_0F0F, 32'd0, 1'b0, 1, 1'b0);
        op("ws1_rd_r7wrap", 1, 1'b0, 32'h8000_001C, 32'd0, 32'd0, 1'b0, 1, 1'b0);
        op("ws1_rd_r3b", 1, 1'b0, 32'h8000_000C, 32'd0, 32'h0F0F_0F0F, 1'b0, 1, 1'b0);

        // Zero wait states, back-to-back reads.
        op("ws0_rd_id", 0, 1'b0, 32'h8000_0000, 32'd0, 32'hA5B0_0001, 1'b0, 0, 1'b1);
        op("ws0_rd_r7", 0, 1'b0, 32'h8000_001C, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        chk("ws0_proto_clean", {31'd0, perr[0]}, 32'd0);

        // Access phase with no setup phase.
        pselx   = 3'b001;
        penable = 1'b1;
        @(posedge hclk); @(negedge hclk);
        chk("ws0_proto_set", {31'd0, perr[0]}, 32'd1);
        chk("ws0_no_ready", {31'd0, rdy[0]}, 32'd0);
        idle();
        op("ws0_rd_after", 0, 1'b0, 32'h8000_0000, 32'd0, 32'hA5B0_0001, 1'b0, 0, 1'b0);
        chk("ws0_proto_sticky", {31'd0, perr[0]}, 32'd1);

        // Three wait states, Psel dropped in the second wait cycle.
        pselx   = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0008;
        pwdata  = 32'hCAFE_F00D;
        @(posedge hclk); @(negedge hclk);
        penable = 1'b1;
        chk("ws3_wait1", {31'd0, rdy[2]}, 32'd0);
        @(posedge hclk); @(negedge hclk);
        pselx = 3'b000;
        @(posedge hclk); @(negedge hclk);
        chk("ws3_abort_proto", {31'd0, perr[2]}, 32'd1);
        chk("ws3_abort_ready", {31'd0, rdy[2]}, 32'd0);
        idle();
        op("ws3_rd_r2", 2, 1'b0, 32'h8000_0008, 32'd0, 32'd0, 1'b0, 3, 1'b0);
        op("ws3_rd_r7", 2, 1'b0, 32'h8000_001C, 32'd0, 32'd0, 1'b0, 3, 1'b0);

        // Reset pulse while a write waits.
        pselx   = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0004;
        pwdata  = 32'h1234_5678;
        @(posedge hclk); @(negedge hclk);
        penable = 1'b1;
        @(posedge hclk); @(negedge hclk);
        #2;
        hreset = 1'b1;
        #1;
        chk("rst_mid_proto", {31'd0, perr[2]}, 32'd0);
        chk("rst_mid_out", {29'd0, rdy[2], serr[2], 1'b0} | rdat[2], 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        idle();
        op("ws3_rd_r1", 2, 1'b0, 32'h8000_0004, 32'd0, 32'd0, 1'b0, 3, 1'b0);
        op("ws1_rd_r1_rst", 1, 1'b0, 32'h8000_0004, 32'd0, 32'd0, 1'b0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
